// File: rtl/uart_cfg_core.sv
// Parametrised UART transceiver: configurable width/parity/stop bits, fixed bit period,
// and a first-word-fall-through receive FIFO that stores per-character error status.
module uart_cfg_core #(
  parameter int DATA_BITS  = 8,
  parameter int CLK_DIV    = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int RX_DEPTH   = 4
) (
  input  logic                             sys_clk,
  input  logic                             sys_rst_l,
  output logic                             uart_XMIT_dataH,
  input  logic                             xmitH,
  input  logic [DATA_BITS-1:0]             xmit_dataH,
  output logic                             xmit_doneH,
  output logic                             tx_busyH,
  input  logic                             uart_REC_dataH,
  output logic [DATA_BITS-1:0]             rec_dataH,
  output logic [1:0]                       rec_errH,
  output logic                             rec_readyH,
  input  logic                             rec_readH,
  output logic [$clog2(RX_DEPTH+1)-1:0]    rec_countH,
  output logic                             overrunH,
  output logic [2:0]                       tx_state,
  output logic [2:0]                       rx_state
);
  // Handshakes: a transmit request is taken on any edge where xmitH=1 and the TX FSM is idle
  // (tx_busyH=0); rec_dataH/rec_errH are valid while rec_readyH=1 and are consumed on an edge
  // where rec_readH=1 and rec_readyH=1.
  localparam int          AW        = $clog2(RX_DEPTH);
  localparam int          CW        = $clog2(RX_DEPTH + 1);
  localparam logic [15:0] DIV_M1    = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_M1   = 16'(CLK_DIV / 2 - 1);
  localparam logic [2:0]  LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
  localparam logic        PEN       = (PARITY_EN != 0);
  localparam logic        ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- transmitter ----------------
  state_t               tx_st;
  logic [15:0]          tx_cnt;
  logic [2:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_tick;

  assign tx_tick  = (tx_cnt == DIV_M1);
  assign tx_state = tx_st;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      tx_st           <= S_IDLE;
      tx_cnt          <= '0;
      tx_bit          <= '0;
      tx_sh           <= '0;
      tx_par          <= 1'b0;
      uart_XMIT_dataH <= 1'b1;
      xmit_doneH      <= 1'b0;
      tx_busyH        <= 1'b0;
    end else begin
      xmit_doneH <= 1'b0;
      if (tx_st != S_IDLE) tx_cnt <= tx_tick ? 16'd0 : tx_cnt + 16'd1;
      case (tx_st)
        S_IDLE: if (xmitH) begin
          tx_st           <= S_START;
          tx_cnt          <= '0;
          tx_sh           <= xmit_dataH;
          tx_par          <= (^xmit_dataH) ^ ODD;
          tx_busyH        <= 1'b1;
          uart_XMIT_dataH <= 1'b0;
        end
        S_START: if (tx_tick) begin
          tx_st           <= S_DATA;
          tx_bit          <= '0;
          uart_XMIT_dataH <= tx_sh[0];
          tx_sh           <= tx_sh >> 1;
        end
        S_DATA: if (tx_tick) begin
          if (tx_bit == LAST_DATA) begin
            tx_bit <= '0;
            if (PEN) begin
              tx_st           <= S_PARITY;
              uart_XMIT_dataH <= tx_par;
            end else begin
              tx_st           <= S_STOP;
              uart_XMIT_dataH <= 1'b1;
            end
          end else begin
            tx_bit          <= tx_bit + 3'd1;
            uart_XMIT_dataH <= tx_sh[0];
            tx_sh           <= tx_sh >> 1;
          end
        end
        S_PARITY: if (tx_tick) begin
          tx_st           <= S_STOP;
          uart_XMIT_dataH <= 1'b1;
        end
        S_STOP: if (tx_tick) begin
          if (tx_bit == LAST_STOP) begin
            tx_st      <= S_IDLE;
            tx_busyH   <= 1'b0;
            xmit_doneH <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 3'd1;
          end
        end
        default: tx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- receiver ----------------
  state_t               rx_st;
  logic                 rx_s1, rx_s2, rx_s3;
  logic [15:0]          rx_cnt;
  logic [2:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr;
  logic                 rx_tick, rx_fall;
  logic                 push_v;
  logic [DATA_BITS+1:0] push_word;

  // The start bit is sampled at half a bit period, every later bit one full period on.
  assign rx_tick  = (rx_st == S_START) ? (rx_cnt == HALF_M1) : (rx_cnt == DIV_M1);
  assign rx_fall  = rx_s3 & ~rx_s2;
  assign rx_state = rx_st;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_s3     <= 1'b1;
      rx_st     <= S_IDLE;
      rx_cnt    <= '0;
      rx_bit    <= '0;
      rx_sh     <= '0;
      rx_perr   <= 1'b0;
      push_v    <= 1'b0;
      push_word <= '0;
    end else begin
      rx_s1  <= uart_REC_dataH;
      rx_s2  <= rx_s1;
      rx_s3  <= rx_s2;
      push_v <= 1'b0;
      if (rx_st != S_IDLE) rx_cnt <= rx_tick ? 16'd0 : rx_cnt + 16'd1;
      case (rx_st)
        S_IDLE: if (rx_fall) begin
          rx_st  <= S_START;
          rx_cnt <= '0;
        end
        S_START: if (rx_tick) begin
          if (rx_s2) rx_st <= S_IDLE;
          else begin
            rx_st   <= S_DATA;
            rx_bit  <= '0;
            rx_perr <= 1'b0;
          end
        end
        S_DATA: if (rx_tick) begin
          rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_bit == LAST_DATA) begin
            rx_bit <= '0;
            rx_st  <= PEN ? S_PARITY : S_STOP;
          end else begin
            rx_bit <= rx_bit + 3'd1;
          end
        end
        S_PARITY: if (rx_tick) begin
          rx_perr <= rx_s2 ^ (^rx_sh) ^ ODD;
          rx_st   <= S_STOP;
        end
        S_STOP: if (rx_tick) begin
          // Only the first stop bit is checked; the receiver re-arms right after it.
          push_v    <= 1'b1;
          push_word <= {rx_perr, ~rx_s2, rx_sh};
          rx_st     <= S_IDLE;
        end
        default: rx_st <= S_IDLE;
      endcase
    end
  end

  // ---------------- receive FIFO ----------------
  logic [DATA_BITS+1:0] mem [RX_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full, do_pop, do_push;
  logic [DATA_BITS+1:0] head;

  assign full    = (count == CW'(RX_DEPTH));
  assign do_pop  = rec_readH && (count != '0);
  assign do_push = push_v && (!full || do_pop);

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overrunH <= 1'b0;
    end else begin
      overrunH <= push_v && full && !do_pop;
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head       = (count != '0) ? mem[rd_ptr] : '0;
  assign rec_dataH  = head[DATA_BITS-1:0];
  assign rec_errH   = head[DATA_BITS+1:DATA_BITS];
  assign rec_readyH = (count != '0);
  assign rec_countH = count;

endmodule

// File: tb/tb_uart_cfg_core.sv
// Bench for uart_cfg_core: an 8N1 instance (A) and a 7-bit odd-parity two-stop instance (B),
// checked against a frame-level model with an expected-character queue.
module tb_uart_cfg_core;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stimulus and selection ----------------
  logic       which;      // 0 drives/observes A, 1 drives/observes B
  logic       xmit_req;
  logic [7:0] xmit_char;
  logic       rx_drv;
  logic       loop;
  logic       rd;

  logic       tx_a, done_a, busy_a, ready_a, ovr_a, rx_a;
  logic [7:0] rdata_a;
  logic [1:0] err_a;
  logic [2:0] count_a, txs_a, rxs_a;
  logic       tx_b, done_b, busy_b, ready_b, ovr_b, rx_b;
  logic [6:0] rdata_b;
  logic [1:0] err_b;
  logic [2:0] count_b, txs_b, rxs_b;

  assign rx_a = (which == 1'b0) ? (loop ? tx_a : rx_drv) : 1'b1;
  assign rx_b = (which == 1'b1) ? (loop ? tx_b : rx_drv) : 1'b1;

  uart_cfg_core dut_a (
    .sys_clk(clk), .sys_rst_l(rst_l),
    .uart_XMIT_dataH(tx_a), .xmitH(xmit_req & ~which), .xmit_dataH(xmit_char),
    .xmit_doneH(done_a), .tx_busyH(busy_a), .uart_REC_dataH(rx_a),
    .rec_dataH(rdata_a), .rec_errH(err_a), .rec_readyH(ready_a), .rec_readH(rd & ~which),
    .rec_countH(count_a), .overrunH(ovr_a), .tx_state(txs_a), .rx_state(rxs_a)
  );

  uart_cfg_core #(.DATA_BITS(7), .CLK_DIV(DIV), .PARITY_EN(1), .PARITY_ODD(1),
                  .STOP_BITS(2), .RX_DEPTH(DEPTH)) dut_b (
    .sys_clk(clk), .sys_rst_l(rst_l),
    .uart_XMIT_dataH(tx_b), .xmitH(xmit_req & which), .xmit_dataH(xmit_char[6:0]),
    .xmit_doneH(done_b), .tx_busyH(busy_b), .uart_REC_dataH(rx_b),
    .rec_dataH(rdata_b), .rec_errH(err_b), .rec_readyH(ready_b), .rec_readH(rd & which),
    .rec_countH(count_b), .overrunH(ovr_b), .tx_state(txs_b), .rx_state(rxs_b)
  );

  logic       m_line, m_done, m_busy, m_ready;
  logic [7:0] m_data;
  logic [1:0] m_err;
  logic [2:0] m_count;
  always_comb begin
    m_line  = which ? tx_b    : tx_a;
    m_done  = which ? done_b  : done_a;
    m_busy  = which ? busy_b  : busy_a;
    m_ready = which ? ready_b : ready_a;
    m_data  = which ? {1'b0, rdata_b} : rdata_a;
    m_err   = which ? err_b   : err_a;
    m_count = which ? count_b : count_a;
  end

  int done_a_cnt = 0;
  int ovr_a_cnt  = 0;
  always @(negedge clk) begin
    if (done_a) done_a_cnt++;
    if (ovr_a)  ovr_a_cnt++;
  end

  // ---------------- scoreboard ----------------
  int         vectors = 0;
  int         miscompares = 0;
  logic [9:0] exp_q[$];   // {parity_err, frame_err, data}
  int         exp_drops = 0;
  int         lat = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int cfg_db(); return which ? 7 : 8; endfunction
  function automatic int cfg_pe(); return which ? 1 : 0; endfunction
  function automatic int cfg_po(); return which ? 1 : 0; endfunction
  function automatic int cfg_sb(); return which ? 2 : 1; endfunction
  function automatic int frame_len(); return 1 + cfg_db() + cfg_pe() + cfg_sb(); endfunction

  // Line level for each bit period of a frame, index 0 = start bit.
  function automatic logic [15:0] make_frame(input logic [7:0] d, input logic flip_par,
                                             input logic stop_low);
    logic [15:0] f = '1;
    logic        p = (cfg_po() != 0);
    int          db = cfg_db();
    f[0] = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[1+i] = d[i];
      p      = p ^ d[i];
    end
    if (cfg_pe() != 0) f[1+db] = p ^ flip_par;
    if (stop_low) f[1+db+cfg_pe()] = 1'b0;
    return f;
  endfunction

  function automatic logic [9:0] exp_entry(input logic [15:0] f);
    int         db = cfg_db();
    int         pe = cfg_pe();
    logic [7:0] d = '0;
    logic       p = (cfg_po() != 0);
    logic       perr = 1'b0;
    logic       ferr;
    for (int i = 0; i < db; i++) begin
      d[i] = f[1+i];
      p    = p ^ f[1+i];
    end
    if (pe != 0) perr = (f[1+db] != p);
    ferr = ~f[1+db+pe];
    return {perr, ferr, d};
  endfunction

  function automatic void model_push(input logic [15:0] f);
    if (exp_q.size() < DEPTH) exp_q.push_back(exp_entry(f));
    else exp_drops++;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_frame(input logic [15:0] f);
    @(posedge clk); #1;
    for (int i = 0; i < frame_len(); i++) begin
      rx_drv = f[i];
      repeat (DIV) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] d, input logic flip_par, input logic stop_low);
    logic [15:0] f;
    f = make_frame(d, flip_par, stop_low);
    drive_frame(f);
    model_push(f);
  endtask

  task automatic tx_frame(input logic [7:0] d);
    logic [15:0] f;
    int n, t, early;
    f = make_frame(d, 1'b0, 1'b0);
    n = frame_len() * DIV;
    t = 0;
    while (m_busy && t < 1000) begin @(posedge clk); #1; t++; end
    check("tx idle before request", m_busy, 0);
    xmit_char = d;
    xmit_req  = 1'b1;
    @(posedge clk); #1;
    xmit_req  = 1'b0;
    xmit_char = 8'($urandom);
    check("tx busy after accept", m_busy, 1);
    early = 0;
    for (int i = 0; i < n; i++) begin
      if (i % DIV == DIV / 2) check($sformatf("tx bit %0d of %0h", i / DIV, d), m_line, f[i/DIV]);
      if (m_done || !m_busy) early++;
      @(posedge clk); #1;
    end
    check("tx done pulse", m_done, 1);
    check("tx busy at done", m_busy, 0);
    check("tx line at done", m_line, 1);
    check("tx early done/idle", early, 0);
    if (loop) model_push(f);
  endtask

  task automatic pop_check(input string tag);
    logic [9:0] e;
    int t;
    t = 0;
    while (!m_ready && t < 2000) begin @(posedge clk); #1; t++; end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h0;
    check({tag, " ready"}, m_ready, 1);
    check({tag, " data"}, m_data, e[7:0]);
    check({tag, " err"}, m_err, e[9:8]);
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  logic [7:0]  c5;
  logic [15:0] f5;
  int          ovr0, drops0, done0;

  initial begin
    which = 1'b0; xmit_req = 1'b0; xmit_char = '0; rx_drv = 1'b1; loop = 1'b0; rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset line", tx_a, 1);
    check("reset done", done_a, 0);
    check("reset busy", busy_a, 0);
    check("reset ready", ready_a, 0);
    check("reset data", rdata_a, 0);
    check("reset err", err_a, 0);
    check("reset count", count_a, 0);
    check("reset overrun", ovr_a, 0);
    check("reset line b", tx_b, 1);
    rst_l = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // 8N1 loopback, back-to-back and random characters
    loop = 1'b1;
    tx_frame(8'hA5);
    pop_check("loop A5");
    tx_frame(8'($urandom));
    tx_frame(8'($urandom));
    pop_check("b2b first");
    pop_check("b2b second");
    for (int i = 0; i < 4; i++) begin
      tx_frame(8'($urandom));
      pop_check("loop random");
    end

    // directly driven RX: frame error, recovery, random stop-bit corruption
    loop = 1'b0;
    rx_frame(8'h3C, 1'b0, 1'b1);
    pop_check("stop low 3C");
    rx_frame(8'($urandom), 1'b0, 1'b0);
    pop_check("after frame err");
    for (int i = 0; i < 6; i++) begin
      rx_frame(8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
      pop_check("rx random");
    end

    // short glitch must not start a character
    @(posedge clk); #1;
    rx_drv = 1'b0;
    repeat (DIV / 4) @(posedge clk);
    #1;
    rx_drv = 1'b1;
    repeat (12 * DIV) @(posedge clk);
    #1;
    check("glitch no push", m_count, 0);
    rx_frame(8'h5E, 1'b0, 1'b0);
    pop_check("after glitch");

    // pop while empty
    rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    check("empty pop count", m_count, 0);
    check("empty pop ready", m_ready, 0);

    // latency, fill and overrun
    ovr0 = ovr_a_cnt; drops0 = exp_drops;
    fork
      rx_frame(8'h11, 1'b0, 1'b0);
      begin
        @(posedge clk);
        lat = 0;
        while (m_count == 0 && lat < 400) begin @(posedge clk); #1; lat++; end
      end
    join
    check("rx latency in range", (lat >= 154 && lat <= 157), 1);
    for (int i = 0; i < 4; i++) rx_frame(8'($urandom), 1'b0, 1'b0);
    check("fifo count full", m_count, exp_q.size());
    check("overrun pulses", ovr_a_cnt - ovr0, exp_drops - drops0);
    for (int i = 0; i < DEPTH; i++) pop_check("drain after overrun");
    check("drained", m_ready, 0);

    // push and pop in the same cycle while full
    for (int i = 0; i < DEPTH; i++) rx_frame(8'($urandom), 1'b0, 1'b0);
    check("refill count", m_count, DEPTH);
    c5 = 8'($urandom);
    f5 = make_frame(c5, 1'b0, 1'b0);
    ovr0 = ovr_a_cnt;
    fork
      drive_frame(f5);
      begin
        @(posedge clk);
        repeat (lat - 1) @(posedge clk);
        #1;
        check("head at same-cycle pop", m_data, exp_q[0][7:0]);
        rd = 1'b1;
        @(posedge clk); #1;
        rd = 1'b0;
      end
    join
    void'(exp_q.pop_front());
    exp_q.push_back(exp_entry(f5));
    check("same-cycle count", m_count, exp_q.size());
    check("same-cycle overrun", ovr_a_cnt - ovr0, 0);
    for (int i = 0; i < DEPTH; i++) pop_check("drain same-cycle");

    // reset in the middle of a loopback frame
    loop = 1'b1;
    xmit_char = 8'h5A;
    xmit_req  = 1'b1;
    @(posedge clk); #1;
    xmit_req = 1'b0;
    repeat (4 * DIV + DIV / 2) @(posedge clk);
    #1;
    done0 = done_a_cnt;
    rst_l = 1'b0;
    #1;
    check("mid reset line", tx_a, 1);
    check("mid reset busy", busy_a, 0);
    check("mid reset count", count_a, 0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_l = 1'b1;
    repeat (12 * DIV) @(posedge clk);
    #1;
    check("no done after reset", done_a_cnt - done0, 0);
    check("fifo empty after reset", count_a, 0);
    tx_frame(8'hC3);
    pop_check("fresh after reset");

    // 7-bit odd parity, two stop bits
    which = 1'b1;
    loop  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tx_frame(8'h35);
    pop_check("b loop 35");
    loop = 1'b0;
    rx_frame(8'h35, 1'b1, 1'b0);
    pop_check("b parity flip");
    for (int i = 0; i < 6; i++) begin
      rx_frame(8'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      pop_check("b rx random");
    end
    loop = 1'b1;
    tx_frame(8'($urandom_range(0, 127)));
    pop_check("b loop random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
